chacha_top: RTL and testbench

- Iterative ChaCha20 block cipher core, per RFC 8439. Encrypts or decrypts one 512-bit block per operation.
- Builds the 16-word state from constants, key, block counter and nonce. Runs 20 rounds, adds the original state, and XORs the keystream with data_in.
- Sits between the message-authentication datapath and key/nonce management. Uses a single start/ready/valid handshake.

---
 rtl/chacha_pkg.sv | 32 +++
 rtl/chacha_quarter_round.sv | 30 +++
 rtl/chacha_top.sv | 169 ++++++++++++++++
 tb/tb_chacha_top.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// ChaCha20 shared definitions: sigma constants, round counts, state type and byte-order helpers.
// Build option CHACHA_SINGLE_ROUND_EN selects one single round per cycle instead of one double round.
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h6170_7865;
  localparam logic [31:0] SIGMA1 = 32'h3320_646e;
  localparam logic [31:0] SIGMA2 = 32'h7962_2d32;
  localparam logic [31:0] SIGMA3 = 32'h6b20_6574;

  localparam int DOUBLE_ROUNDS = 10;
`ifdef CHACHA_SINGLE_ROUND_EN
  localparam int ROUND_CYCLES = 2 * DOUBLE_ROUNDS;
`else
  localparam int ROUND_CYCLES = DOUBLE_ROUNDS;
`endif

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  // Bus order puts byte 0 in the MSBs; the cipher word is little-endian. The swap is self-inverse.
  function automatic word_t pack_word(input logic [31:0] bytes);
    return {bytes[7:0], bytes[15:8], bytes[23:16], bytes[31:24]};
  endfunction

  function automatic logic [511:0] serialize(input state_t s);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[511-32*j -: 32] = pack_word(s[j]);
    return r;
  endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// ChaCha20 quarter round: add / xor / rotate by 16, 12, 8, 7, purely combinational.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_next,
  output word_t b_next,
  output word_t c_next,
  output word_t d_next
);

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  word_t a1, b1, c1, d1;

  assign a1     = a + b;
  assign d1     = rotl(d ^ a1, 16);
  assign c1     = c + d1;
  assign b1     = rotl(b ^ c1, 12);
  assign a_next = a1 + b1;
  assign d_next = rotl(d1 ^ a_next, 8);
  assign c_next = c1 + d_next;
  assign b_next = rotl(b1 ^ c_next, 7);

endmodule

// File: rtl/chacha_top.sv
// Iterative ChaCha20 block core: builds the state, runs 20 rounds, XORs the keystream with data_in.
// Define CHACHA_SINGLE_ROUND_EN for one single round per cycle (21-clock latency instead of 11).
module chacha_top
  import chacha_pkg::*;
#(
  parameter int IN_WIDTH          = 512,
  parameter int KEY_WIDTH         = 256,
  parameter int NONCE_WIDTH       = 96,
  parameter int BLOCK_COUNT_WIDTH = 32,
  parameter int WIDTH             = 32,
  parameter int OUT_WIDTH         = 512
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [KEY_WIDTH-1:0]         key,
  input  logic [NONCE_WIDTH-1:0]       nonce,
  input  logic [BLOCK_COUNT_WIDTH-1:0] block_count,
  input  logic [IN_WIDTH-1:0]          data_in,
  input  logic                         start,
  output logic                         ready,
  output logic                         valid,
  output logic [OUT_WIDTH-1:0]         data_out
);

  if (IN_WIDTH != 512 || KEY_WIDTH != 256 || NONCE_WIDTH != 96 ||
      BLOCK_COUNT_WIDTH != 32 || WIDTH != 32 || OUT_WIDTH != 512) begin : g_param_check
    $error("chacha_top: only the default parameter values are supported");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [4:0] ROUND_LAST = 5'(ROUND_CYCLES - 1);

  logic [1:0]   fsm;
  logic [4:0]   cnt;
  state_t       work, init, init_state, step1, round_next, final_state;
  logic [511:0] din_q;
  logic         diag_sel;

  // Flat state index of quarter-round lane `lane`, row `row` (a=0..d=3), column or diagonal pattern.
  function automatic logic [3:0] lane_idx(input int row, input int lane, input logic diag);
    int col;
    col = diag ? ((lane + row) & 3) : lane;
    return 4'(4 * row + col);
  endfunction

  always_comb begin
    init_state[0]  = SIGMA0;
    init_state[1]  = SIGMA1;
    init_state[2]  = SIGMA2;
    init_state[3]  = SIGMA3;
    for (int j = 0; j < 8; j++) init_state[4+j] = pack_word(key[KEY_WIDTH-1-32*j -: 32]);
    init_state[12] = block_count;
    for (int j = 0; j < 3; j++) init_state[13+j] = pack_word(nonce[NONCE_WIDTH-1-32*j -: 32]);
  end

`ifdef CHACHA_SINGLE_ROUND_EN
  assign diag_sel = cnt[0];
`else
  assign diag_sel = 1'b0;
`endif

  word_t [3:0] a1, b1, c1, d1, a1n, b1n, c1n, d1n;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a1[i] = work[lane_idx(0, i, diag_sel)];
      b1[i] = work[lane_idx(1, i, diag_sel)];
      c1[i] = work[lane_idx(2, i, diag_sel)];
      d1[i] = work[lane_idx(3, i, diag_sel)];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_bank1
    chacha_quarter_round u_qr (
      .a(a1[i]), .b(b1[i]), .c(c1[i]), .d(d1[i]),
      .a_next(a1n[i]), .b_next(b1n[i]), .c_next(c1n[i]), .d_next(d1n[i])
    );
  end

  // NOTE: combinational blocks use blocking '=' and assign a full default first, so no latch is inferred.
  always_comb begin
    step1 = work;
    for (int i = 0; i < 4; i++) begin
      step1[lane_idx(0, i, diag_sel)] = a1n[i];
      step1[lane_idx(1, i, diag_sel)] = b1n[i];
      step1[lane_idx(2, i, diag_sel)] = c1n[i];
      step1[lane_idx(3, i, diag_sel)] = d1n[i];
    end
  end

`ifdef CHACHA_SINGLE_ROUND_EN
  assign round_next = step1;
`else
  word_t [3:0] a2, b2, c2, d2, a2n, b2n, c2n, d2n;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a2[i] = step1[lane_idx(0, i, 1'b1)];
      b2[i] = step1[lane_idx(1, i, 1'b1)];
      c2[i] = step1[lane_idx(2, i, 1'b1)];
      d2[i] = step1[lane_idx(3, i, 1'b1)];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_bank2
    chacha_quarter_round u_qr (
      .a(a2[i]), .b(b2[i]), .c(c2[i]), .d(d2[i]),
      .a_next(a2n[i]), .b_next(b2n[i]), .c_next(c2n[i]), .d_next(d2n[i])
    );
  end

  always_comb begin
    round_next = step1;
    for (int i = 0; i < 4; i++) begin
      round_next[lane_idx(0, i, 1'b1)] = a2n[i];
      round_next[lane_idx(1, i, 1'b1)] = b2n[i];
      round_next[lane_idx(2, i, 1'b1)] = c2n[i];
      round_next[lane_idx(3, i, 1'b1)] = d2n[i];
    end
  end
`endif

  always_comb begin
    for (int j = 0; j < 16; j++) final_state[j] = work[j] + init[j];
  end

  assign ready = (fsm == IDLE);

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the wide data registers are reset too, so an aborted operation leaves no key material visible.
      fsm      <= IDLE;
      cnt      <= '0;
      work     <= '0;
      init     <= '0;
      din_q    <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            init  <= init_state;
            work  <= init_state;
            din_q <= data_in;
            cnt   <= '0;
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          work <= round_next;
          cnt  <= cnt + 5'd1;
          if (cnt == ROUND_LAST) fsm <= FINAL;
        end
        FINAL: begin
          data_out <= din_q ^ serialize(final_state);
          valid    <= 1'b1;
          fsm      <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_top.sv
// Self-checking bench for chacha_top: RFC 8439 vectors, a byte-level reference model and handshake corner cases.
module tb_chacha_top;

`ifdef CHACHA_SINGLE_ROUND_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 11;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  block_count;
  logic [511:0] data_in;
  logic         start;
  logic         ready;
  logic         valid;
  logic [511:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  chacha_top dut (
    .clk(clk), .resetn(resetn), .key(key), .nonce(nonce), .block_count(block_count),
    .data_in(data_in), .start(start), .ready(ready), .valid(valid), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RFC 8439 quarter-round index table: four columns, then four diagonals.
  localparam int QI [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                               '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] bc, input logic [511:0] din);
    logic [7:0]   kb [32];
    logic [7:0]   nb [12];
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [31:0]  w;
    logic [511:0] r;
    for (int i = 0; i < 32; i++) kb[i] = k[255-8*i -: 8];
    for (int i = 0; i < 12; i++) nb[i] = n[95-8*i -: 8];
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4+j] = {kb[4*j+3], kb[4*j+2], kb[4*j+1], kb[4*j]};
    s[12] = bc;
    for (int j = 0; j < 3; j++) s[13+j] = {nb[4*j+3], nb[4*j+2], nb[4*j+1], nb[4*j]};
    x = s;
    for (int dr = 0; dr < 10; dr++) begin
      for (int q = 0; q < 8; q++) begin
        int a, b, c, d;
        a = QI[q][0]; b = QI[q][1]; c = QI[q][2]; d = QI[q][3];
        x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 7);
      end
    end
    r = din;
    for (int j = 0; j < 16; j++) begin
      w = x[j] + s[j];
      for (int bi = 0; bi < 4; bi++) r[511-8*(4*j+bi) -: 8] ^= w[8*bi +: 8];
    end
    return r;
  endfunction

  // One operation: start at the next edge, optionally scramble inputs after acceptance, wait for valid.
  task automatic run_op(input logic [255:0] k, input logic [95:0] n, input logic [31:0] bc,
                        input logic [511:0] din, input bit perturb,
                        output logic [511:0] res, output int lat);
    @(negedge clk);
    key = k; nonce = n; block_count = bc; data_in = din; start = 1'b1;
    lat = -1;
    res = '0;
    for (int c = 0; c <= LAT + 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        check("busy_ready", 512'(ready), 512'(0));
        if (perturb) begin
          key = ~k; nonce = ~n; block_count = bc + 32'd1; data_in = ~din;
        end
      end
      if (valid) begin
        lat = c;
        res = data_out;
        break;
      end
    end
    @(negedge clk);
    check("valid_one_cycle", 512'(valid), 512'(0));
    check("hold_data_out", data_out, res);
  endtask

  initial begin
    logic [255:0] k_rfc, k_r;
    logic [95:0]  n_rfc, n_r;
    logic [31:0]  bc_r;
    logic [511:0] d_r, exp1, res, res1, captured;
    int           lat, pulses, prev;

    for (int i = 0; i < 32; i++) k_rfc[255-8*i -: 8] = 8'(i);
    n_rfc = 96'h000000090000004a00000000;
    exp1  = ref_block(k_rfc, n_rfc, 32'd1, 512'h1);

    resetn = 1'b0; start = 1'b0; key = '0; nonce = '0; block_count = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 512'(ready), 512'(1));
    check("reset_valid", 512'(valid), 512'(0));
    check("reset_data_out", data_out, 512'(0));
    resetn = 1'b1;

    run_op(k_rfc, n_rfc, 32'd1, 512'h1, 1'b0, res, lat);
    check("rfc_latency", 512'(lat), 512'(LAT));
    check("rfc_head", 512'(res[511:384]), 512'(128'h10f1e7e4d13b5915500fdd1fa32071c4));
    check("rfc_tail", 512'(res[31:0]), 512'(32'ha2503c4f));
    check("rfc_model", res, exp1);
    res1 = res;

    run_op('0, '0, '0, '0, 1'b0, res, lat);
    check("zero_head", 512'(res[511:384]), 512'(128'h76b8e0ada0f13d90405d6ae55386bd28));
    check("zero_model", res, ref_block('0, '0, '0, '0));

    run_op(k_rfc, n_rfc, 32'd1, res1, 1'b0, res, lat);
    check("involution", res, 512'h1);

    run_op(k_rfc, n_rfc, 32'd1, 512'h1, 1'b1, res, lat);
    check("inputs_ignored_after_accept", res, exp1);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) k_r[32*i +: 32] = $urandom;
      for (int i = 0; i < 3; i++) n_r[32*i +: 32] = $urandom;
      for (int i = 0; i < 16; i++) d_r[32*i +: 32] = $urandom;
      bc_r = (t == 3) ? 32'hffff_ffff : $urandom;
      run_op(k_r, n_r, bc_r, d_r, 1'b0, res, lat);
      check("random_latency", 512'(lat), 512'(LAT));
      check("random_model", res, ref_block(k_r, n_r, bc_r, d_r));
    end

    // start held high for 40 edges: back-to-back operations, new one accepted during the valid cycle.
    @(negedge clk);
    key = k_rfc; nonce = n_rfc; block_count = 32'd1; data_in = 512'h1; start = 1'b1;
    pulses = 0; prev = -1;
    for (int c = 0; c < 40 + 2 * LAT + 4; c++) begin
      @(negedge clk);
      if (c == 39) start = 1'b0;
      if (valid) begin
        check("b2b_data", data_out, exp1);
        if (prev >= 0) check("b2b_period", 512'(c - prev), 512'(LAT + 1));
        else check("b2b_first", 512'(c), 512'(LAT));
        prev = c;
        pulses++;
      end
    end
    check("b2b_count", 512'(pulses), 512'((40 + LAT) / (LAT + 1)));

    // start pulsed while busy must be ignored.
    for (int i = 0; i < 8; i++) k_r[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) d_r[32*i +: 32] = $urandom;
    @(negedge clk);
    key = k_r; nonce = n_rfc; block_count = 32'd7; data_in = d_r; start = 1'b1;
    pulses = 0; captured = '0;
    for (int c = 0; c < 2 * LAT + 4; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 7);
      if (valid) begin
        pulses++;
        captured = data_out;
      end
    end
    check("busy_start_pulses", 512'(pulses), 512'(1));
    check("busy_start_data", captured, ref_block(k_r, n_rfc, 32'd7, d_r));

    // Reset during ROUND with the counter at 5 aborts the operation.
    @(negedge clk);
    key = k_rfc; nonce = n_rfc; block_count = 32'd1; data_in = 512'h1; start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check("abort_valid", 512'(valid), 512'(0));
    check("abort_data_out", data_out, 512'(0));
    check("abort_ready", 512'(ready), 512'(1));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("abort_no_valid", 512'(pulses), 512'(0));
    run_op(k_rfc, n_rfc, 32'd1, 512'h1, 1'b0, res, lat);
    check("after_abort_latency", 512'(lat), 512'(LAT));
    check("after_abort_data", res, exp1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
